// File: rtl/nf10_axis_pkt_gen_pkg.sv
// Shared types and helpers for the AXI4-Stream packet generator.
package nf10_axis_pkt_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  // NetFPGA tuser field positions
  localparam int LEN_LSB = 0;
  localparam int SRC_LSB = 16;
  localparam int DST_LSB = 24;

  function automatic int beats_for_len(input logic [15:0] len, input int bytes_per_beat);
    return (int'(len) + bytes_per_beat - 1) / bytes_per_beat;
  endfunction

endpackage

// File: rtl/nf10_axis_pkt_gen_beat.sv
// Combinational beat builder: byte pattern (p + beat*bytes + lane) mod 256
// and byte enables trimmed on a partial final beat.
module nf10_axis_pkt_gen_beat #(
  parameter int DATA_WIDTH = 256,
  parameter int BEAT_W     = 11
) (
  input  logic [7:0]              p,
  input  logic [BEAT_W-1:0]       beat_idx,
  input  logic [15:0]             pkt_len,
  input  logic                    is_last,
  output logic [DATA_WIDTH-1:0]   tdata,
  output logic [DATA_WIDTH/8-1:0] tstrb
);

  localparam int BYTES = DATA_WIDTH / 8;

  logic [7:0]  base;
  logic [15:0] rem;

  assign base = p + 8'(32'(beat_idx) * BYTES);
  assign rem  = 16'(32'(pkt_len) % BYTES);

  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_lane
      assign tdata[8*gi +: 8] = base + 8'(gi);
      assign tstrb[gi]        = !is_last || (rem == 16'd0) || (16'(gi) < rem);
    end
  endgenerate

endmodule

// File: rtl/nf10_axis_pkt_gen.sv
// AXI4-Stream packet source: on start, emits num_pkts packets of pkt_len bytes
// with a counting byte pattern and NetFPGA tuser metadata.
module nf10_axis_pkt_gen
  import nf10_axis_pkt_gen_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_IPG                = 0
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic                              start,
  input  logic [15:0]                       pkt_len,
  input  logic [7:0]                        num_pkts,
  input  logic [7:0]                        src_port,
  input  logic [7:0]                        dst_port,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic [7:0]                        counter,
  output logic                              activity_send,
  output logic                              busy,
  output logic                              err
);

  localparam int BYTES  = C_M_AXIS_DATA_WIDTH / 8;
  localparam int BEAT_W = $clog2((65535 + BYTES - 1) / BYTES);

  state_t                            state_reg;
  logic [15:0]                       len_reg;
  logic [7:0]                        num_pkts_reg;
  logic [BEAT_W-1:0]                 last_beat_reg;
  logic [BEAT_W-1:0]                 beat_reg;
  logic [7:0]                        p_reg;
  logic [7:0]                        gap_reg;
  logic [7:0]                        counter_reg;
  logic                              act_reg;
  logic                              busy_reg;
  logic                              err_reg;
  logic                              tvalid_reg;
  logic                              tlast_reg;
  logic [C_M_AXIS_DATA_WIDTH-1:0]    tdata_reg;
  logic [BYTES-1:0]                  tstrb_reg;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]   tuser_reg;

  logic                              hs;
  logic                              pkt_done;
  logic                              run_done;
  logic                              load_en;
  logic [BEAT_W-1:0]                 ld_beat;
  logic [7:0]                        ld_p;
  logic                              ld_last;
  logic [C_M_AXIS_DATA_WIDTH-1:0]    beat_tdata;
  logic [BYTES-1:0]                  beat_tstrb;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]   tuser_next;

  assign hs       = tvalid_reg && m_axis_tready;
  assign pkt_done = hs && tlast_reg;
  assign run_done = pkt_done && ((counter_reg + 8'd1) == num_pkts_reg);

  // The holding register is refilled when empty in SEND, after every accepted
  // beat within a packet, at a back-to-back packet boundary, or at gap end.
  assign load_en = ((state_reg == SEND) &&
                    (!tvalid_reg || (hs && !tlast_reg) || (pkt_done && !run_done && (C_IPG == 0))))
                || ((state_reg == GAP) && (gap_reg == 8'd0));

  // A valid non-last beat means we are mid-packet; otherwise a new packet starts.
  assign ld_beat = (tvalid_reg && !tlast_reg) ? beat_reg + BEAT_W'(1) : '0;
  assign ld_p    = (tvalid_reg && tlast_reg) ? p_reg + 8'd1 : p_reg;
  assign ld_last = (ld_beat == last_beat_reg);

  always_comb begin
    tuser_next = '0;
    tuser_next[LEN_LSB +: 16] = pkt_len;
    tuser_next[SRC_LSB +: 8]  = src_port;
    tuser_next[DST_LSB +: 8]  = dst_port;
  end

  nf10_axis_pkt_gen_beat #(
    .DATA_WIDTH (C_M_AXIS_DATA_WIDTH),
    .BEAT_W     (BEAT_W)
  ) u_beat (
    .p        (ld_p),
    .beat_idx (ld_beat),
    .pkt_len  (len_reg),
    .is_last  (ld_last),
    .tdata    (beat_tdata),
    .tstrb    (beat_tstrb)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg     <= IDLE;
      len_reg       <= '0;
      num_pkts_reg  <= '0;
      last_beat_reg <= '0;
      beat_reg      <= '0;
      p_reg         <= '0;
      gap_reg       <= '0;
      counter_reg   <= '0;
      act_reg       <= 1'b0;
      busy_reg      <= 1'b0;
      err_reg       <= 1'b0;
      tvalid_reg    <= 1'b0;
      tlast_reg     <= 1'b0;
      tdata_reg     <= '0;
      tstrb_reg     <= '0;
      tuser_reg     <= '0;
    end else begin
      act_reg <= pkt_done;

      if (load_en) begin
        tvalid_reg <= 1'b1;
        tdata_reg  <= beat_tdata;
        tstrb_reg  <= beat_tstrb;
        tlast_reg  <= ld_last;
        beat_reg   <= ld_beat;
      end else if (hs) begin
        tvalid_reg <= 1'b0;
        tlast_reg  <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (start) begin
            if ((pkt_len == 16'd0) || (num_pkts == 8'd0)) begin
              err_reg <= 1'b1;
            end else begin
              len_reg       <= pkt_len;
              num_pkts_reg  <= num_pkts;
              last_beat_reg <= BEAT_W'(beats_for_len(pkt_len, BYTES) - 1);
              tuser_reg     <= tuser_next;
              counter_reg   <= '0;
              p_reg         <= '0;
              err_reg       <= 1'b0;
              busy_reg      <= 1'b1;
              state_reg     <= SEND;
            end
          end
        end
        SEND: begin
          if (pkt_done) begin
            counter_reg <= counter_reg + 8'd1;
            p_reg       <= p_reg + 8'd1;
            if (run_done) begin
              state_reg <= DONE;
            end else if (C_IPG > 0) begin
              state_reg <= GAP;
              gap_reg   <= 8'(C_IPG - 1);
            end
          end
        end
        GAP: begin
          if (gap_reg == 8'd0) state_reg <= SEND;
          else                 gap_reg   <= gap_reg - 8'd1;
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign m_axis_tdata  = tdata_reg;
  assign m_axis_tstrb  = tstrb_reg;
  assign m_axis_tuser  = tuser_reg;
  assign m_axis_tvalid = tvalid_reg;
  assign m_axis_tlast  = tlast_reg;
  assign counter       = counter_reg;
  assign activity_send = act_reg;
  assign busy          = busy_reg;
  assign err           = err_reg;

endmodule

// File: tb/tb_nf10_axis_pkt_gen.sv
// Directed bench for nf10_axis_pkt_gen: one gapped instance (C_IPG=4) and one
// back-to-back instance (C_IPG=0).
module tb_nf10_axis_pkt_gen;

  localparam int DW = 256;
  localparam int UW = 128;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          start = 1'b0;
  logic          start_b = 1'b0;
  logic [15:0]   pkt_len = '0;
  logic [7:0]    num_pkts = '0;
  logic [7:0]    src_port = '0;
  logic [7:0]    dst_port = '0;
  logic          m_axis_tready = 1'b0;

  logic [DW-1:0]   m_axis_tdata;
  logic [DW/8-1:0] m_axis_tstrb;
  logic [UW-1:0]   m_axis_tuser;
  logic            m_axis_tvalid;
  logic            m_axis_tlast;
  logic [7:0]      counter;
  logic            activity_send;
  logic            busy;
  logic            err;

  logic [DW-1:0]   b_tdata;
  logic [DW/8-1:0] b_tstrb;
  logic [UW-1:0]   b_tuser;
  logic            b_tvalid;
  logic            b_tlast;
  logic [7:0]      b_counter;
  logic            b_activity;
  logic            b_busy;
  logic            b_err;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 aclk = ~aclk;

  nf10_axis_pkt_gen #(
    .C_M_AXIS_DATA_WIDTH (DW),
    .C_M_AXIS_TUSER_WIDTH(UW),
    .C_IPG               (4)
  ) u_dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .start         (start),
    .pkt_len       (pkt_len),
    .num_pkts      (num_pkts),
    .src_port      (src_port),
    .dst_port      (dst_port),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .counter       (counter),
    .activity_send (activity_send),
    .busy          (busy),
    .err           (err)
  );

  nf10_axis_pkt_gen #(
    .C_M_AXIS_DATA_WIDTH (DW),
    .C_M_AXIS_TUSER_WIDTH(UW),
    .C_IPG               (0)
  ) u_b2b (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .start         (start_b),
    .pkt_len       (pkt_len),
    .num_pkts      (num_pkts),
    .src_port      (src_port),
    .dst_port      (dst_port),
    .m_axis_tdata  (b_tdata),
    .m_axis_tstrb  (b_tstrb),
    .m_axis_tuser  (b_tuser),
    .m_axis_tvalid (b_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (b_tlast),
    .counter       (b_counter),
    .activity_send (b_activity),
    .busy          (b_busy),
    .err           (b_err)
  );

  // Byte pattern of beat b in packet p: lane i = (p + 32b + i) mod 256.
  function automatic logic [DW-1:0] exp_beat(input int p, input int b);
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 8; i++) v[8*i +: 8] = 8'(p + 32 * b + i);
    return v;
  endfunction

  // Called at a falling edge; returns at the falling edge after the sampling edge.
  task automatic do_start(input logic [15:0] len, input logic [7:0] n,
                          input logic [7:0] src, input logic [7:0] dst);
    pkt_len  = len;
    num_pkts = n;
    src_port = src;
    dst_port = dst;
    start    = 1'b1;
    @(negedge aclk);
    start    = 1'b0;
    $display("start len=%0d num_pkts=%0d src=%h dst=%h", len, n, src, dst);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge aclk);
    n_cmp++; if ({m_axis_tvalid, m_axis_tlast, activity_send, busy, err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00000", {m_axis_tvalid, m_axis_tlast, activity_send, busy, err});
    end
    n_cmp++; if (m_axis_tdata !== '0 || m_axis_tstrb !== '0 || m_axis_tuser !== '0) begin
      n_fail++; $display("FAIL reset_data: tdata=%h tstrb=%h tuser=%h expected all 0", m_axis_tdata, m_axis_tstrb, m_axis_tuser);
    end
    n_cmp++; if (counter !== 8'd0 || b_tvalid !== 1'b0 || b_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_counter: counter=%0d b_tvalid=%b b_busy=%b expected 0", counter, b_tvalid, b_busy);
    end
    aresetn = 1'b1;
    @(negedge aclk);
    n_cmp++; if (busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: busy=%b tvalid=%b expected 0 0", busy, m_axis_tvalid);
    end
  endtask

  task automatic test_single();
    m_axis_tready = 1'b1;
    do_start(16'd64, 8'd1, 8'h01, 8'h04);
    n_cmp++; if (busy !== 1'b1 || m_axis_tvalid !== 1'b0) begin
      n_fail++; $display("FAIL single_latency: busy=%b tvalid=%b expected busy=1 tvalid=0", busy, m_axis_tvalid);
    end
    @(negedge aclk);
    $display("beat pkt=0 beat=0 tdata[7:0]=%h tstrb=%h tlast=%b", m_axis_tdata[7:0], m_axis_tstrb, m_axis_tlast);
    n_cmp++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata[7:0] !== 8'h00) begin
      n_fail++; $display("FAIL single_b0_lane0: tvalid=%b byte=%h expected 1 00", m_axis_tvalid, m_axis_tdata[7:0]);
    end
    n_cmp++; if (m_axis_tdata !== exp_beat(0, 0)) begin
      n_fail++; $display("FAIL single_b0_data: got %h expected %h", m_axis_tdata, exp_beat(0, 0));
    end
    n_cmp++; if (m_axis_tstrb !== 32'hFFFF_FFFF || m_axis_tlast !== 1'b0) begin
      n_fail++; $display("FAIL single_b0_strb: tstrb=%h tlast=%b expected ffffffff 0", m_axis_tstrb, m_axis_tlast);
    end
    n_cmp++; if (m_axis_tuser[31:0] !== 32'h0401_0040 || m_axis_tuser[UW-1:32] !== '0) begin
      n_fail++; $display("FAIL single_tuser: got %h expected 04010040 with upper bits 0", m_axis_tuser);
    end
    @(negedge aclk);
    $display("beat pkt=0 beat=1 tdata[255:248]=%h tstrb=%h tlast=%b", m_axis_tdata[255:248], m_axis_tstrb, m_axis_tlast);
    n_cmp++; if (m_axis_tdata[255:248] !== 8'h3F || m_axis_tdata !== exp_beat(0, 1)) begin
      n_fail++; $display("FAIL single_b1_data: got %h expected %h", m_axis_tdata, exp_beat(0, 1));
    end
    n_cmp++; if (m_axis_tstrb !== 32'hFFFF_FFFF || m_axis_tlast !== 1'b1 || m_axis_tvalid !== 1'b1) begin
      n_fail++; $display("FAIL single_b1_last: tstrb=%h tlast=%b tvalid=%b expected ffffffff 1 1", m_axis_tstrb, m_axis_tlast, m_axis_tvalid);
    end
    @(negedge aclk);
    n_cmp++; if (m_axis_tvalid !== 1'b0 || activity_send !== 1'b1 || counter !== 8'd1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_done: tvalid=%b act=%b counter=%0d busy=%b expected 0 1 1 1", m_axis_tvalid, activity_send, counter, busy);
    end
    @(negedge aclk);
    n_cmp++; if (busy !== 1'b0 || activity_send !== 1'b0 || counter !== 8'd1) begin
      n_fail++; $display("FAIL single_idle: busy=%b act=%b counter=%0d expected 0 0 1", busy, activity_send, counter);
    end
  endtask

  task automatic test_partial();
    m_axis_tready = 1'b1;
    do_start(16'd61, 8'd1, 8'h02, 8'h08);
    @(negedge aclk);
    n_cmp++; if (m_axis_tstrb !== 32'hFFFF_FFFF || m_axis_tlast !== 1'b0) begin
      n_fail++; $display("FAIL partial_b0: tstrb=%h tlast=%b expected ffffffff 0", m_axis_tstrb, m_axis_tlast);
    end
    @(negedge aclk);
    $display("beat len=61 beat=1 tstrb=%h tlast=%b", m_axis_tstrb, m_axis_tlast);
    n_cmp++; if (m_axis_tstrb !== 32'h1FFF_FFFF || m_axis_tlast !== 1'b1) begin
      n_fail++; $display("FAIL partial_b1: tstrb=%h tlast=%b expected 1fffffff 1", m_axis_tstrb, m_axis_tlast);
    end
    n_cmp++; if (m_axis_tdata !== exp_beat(0, 1)) begin
      n_fail++; $display("FAIL partial_b1_data: got %h expected %h", m_axis_tdata, exp_beat(0, 1));
    end
    repeat (2) @(negedge aclk);
    do_start(16'd1, 8'd1, 8'h02, 8'h08);
    @(negedge aclk);
    $display("beat len=1 beat=0 tstrb=%h tlast=%b", m_axis_tstrb, m_axis_tlast);
    n_cmp++; if (m_axis_tvalid !== 1'b1 || m_axis_tstrb !== 32'h0000_0001 || m_axis_tlast !== 1'b1) begin
      n_fail++; $display("FAIL len1_beat: tvalid=%b tstrb=%h tlast=%b expected 1 00000001 1", m_axis_tvalid, m_axis_tstrb, m_axis_tlast);
    end
    n_cmp++; if (m_axis_tdata[7:0] !== 8'h00 || m_axis_tuser[15:0] !== 16'd1) begin
      n_fail++; $display("FAIL len1_meta: byte0=%h len=%h expected 00 0001", m_axis_tdata[7:0], m_axis_tuser[15:0]);
    end
    @(negedge aclk);
    n_cmp++; if (m_axis_tvalid !== 1'b0 || counter !== 8'd1) begin
      n_fail++; $display("FAIL len1_done: tvalid=%b counter=%0d expected 0 1", m_axis_tvalid, counter);
    end
    @(negedge aclk);
  endtask

  task automatic test_backpressure();
    bit              prev_stall;
    bit              finished;
    logic [DW-1:0]   pd;
    logic [DW/8-1:0] ps;
    logic [UW-1:0]   pu;
    logic            pl;
    int              pk;
    int              bt;
    int              pulses;
    prev_stall = 0; finished = 0; pk = 0; bt = 0; pulses = 0;
    pd = '0; ps = '0; pu = '0; pl = 1'b0;
    m_axis_tready = 1'b1;
    do_start(16'd100, 8'd3, 8'h10, 8'h20);
    for (int c = 0; c < 2000; c++) begin
      @(negedge aclk);
      if (activity_send) pulses++;
      if (prev_stall) begin
        n_cmp++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== pd || m_axis_tstrb !== ps ||
                     m_axis_tuser !== pu || m_axis_tlast !== pl) begin
          n_fail++; $display("FAIL bp_stable: tvalid=%b tdata=%h expected 1 %h", m_axis_tvalid, m_axis_tdata, pd);
        end
      end
      if (m_axis_tvalid) begin
        n_cmp++; if (m_axis_tdata !== exp_beat(pk, bt)) begin
          n_fail++; $display("FAIL bp_data p=%0d b=%0d: got %h expected %h", pk, bt, m_axis_tdata, exp_beat(pk, bt));
        end
        n_cmp++; if (m_axis_tstrb !== ((bt == 3) ? 32'h0000_000F : 32'hFFFF_FFFF) || m_axis_tlast !== (bt == 3)) begin
          n_fail++; $display("FAIL bp_strb p=%0d b=%0d: tstrb=%h tlast=%b", pk, bt, m_axis_tstrb, m_axis_tlast);
        end
      end
      if (pk == 3 && !busy) begin
        finished = 1;
        break;
      end
      m_axis_tready = ($urandom_range(0, 9) < 3);
      prev_stall = m_axis_tvalid && !m_axis_tready;
      pd = m_axis_tdata; ps = m_axis_tstrb; pu = m_axis_tuser; pl = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready) begin
        $display("beat pkt=%0d beat=%0d tdata[7:0]=%h tstrb=%h tlast=%b", pk, bt, m_axis_tdata[7:0], m_axis_tstrb, m_axis_tlast);
        if (bt == 3) begin bt = 0; pk++; end
        else bt++;
      end
    end
    m_axis_tready = 1'b1;
    n_cmp++; if (!finished) begin
      n_fail++; $display("FAIL bp_timeout: packets=%0d busy=%b expected 3 packets then idle", pk, busy);
    end
    n_cmp++; if (counter !== 8'd3 || pulses !== 3) begin
      n_fail++; $display("FAIL bp_count: counter=%0d pulses=%0d expected 3 3", counter, pulses);
    end
  endtask

  task automatic test_gap_reject();
    int  gaps_seen;
    int  gap_len;
    int  pk;
    int  hs;
    bit  counting;
    bit  any_valid;
    bit  finished;
    gaps_seen = 0; gap_len = 0; pk = 0; counting = 0; any_valid = 0; finished = 0; hs = 0;
    m_axis_tready = 1'b1;
    do_start(16'd32, 8'd3, 8'h01, 8'h02);
    for (int c = 0; c < 200; c++) begin
      @(negedge aclk);
      if (m_axis_tvalid) begin
        if (counting) begin
          $display("gap before pkt=%0d idle_cycles=%0d", pk, gap_len);
          n_cmp++; if (gap_len !== 4) begin
            n_fail++; $display("FAIL gap_len pkt=%0d: got %0d expected 4", pk, gap_len);
          end
          gaps_seen++;
          counting = 0;
        end
        n_cmp++; if (m_axis_tdata[7:0] !== 8'(pk)) begin
          n_fail++; $display("FAIL gap_pkt_byte pkt=%0d: got %h expected %h", pk, m_axis_tdata[7:0], 8'(pk));
        end
        if (m_axis_tlast) begin pk++; counting = 1; gap_len = 0; end
      end else if (counting) gap_len++;
      if (pk == 3 && !busy) break;
    end
    n_cmp++; if (gaps_seen !== 2 || pk !== 3) begin
      n_fail++; $display("FAIL gap_count: gaps=%0d pkts=%0d expected 2 3", gaps_seen, pk);
    end

    do_start(16'd64, 8'd0, 8'h01, 8'h02);
    n_cmp++; if (err !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reject_err: err=%b busy=%b expected 1 0", err, busy);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      if (m_axis_tvalid) any_valid = 1;
    end
    n_cmp++; if (any_valid) begin
      n_fail++; $display("FAIL reject_traffic: tvalid seen=1 expected 0");
    end

    do_start(16'd64, 8'd2, 8'h01, 8'h02);
    n_cmp++; if (err !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL accept_clears_err: err=%b busy=%b expected 0 1", err, busy);
    end
    pkt_len  = 16'd0;
    num_pkts = 8'd0;
    for (int c = 0; c < 60; c++) begin
      @(negedge aclk);
      if (m_axis_tvalid) hs++;
      if (!busy) begin finished = 1; break; end
      start = (c == 0);
    end
    start = 1'b0;
    $display("busy-start run beats=%0d counter=%0d err=%b", hs, counter, err);
    n_cmp++; if (!finished || hs !== 4 || counter !== 8'd2) begin
      n_fail++; $display("FAIL busy_start_run: finished=%b beats=%0d counter=%0d expected 1 4 2", finished, hs, counter);
    end
    n_cmp++; if (err !== 1'b0) begin
      n_fail++; $display("FAIL busy_start_err: err=%b expected 0", err);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 0;
    m_axis_tready = 1'b1;
    do_start(16'd128, 8'd2, 8'h03, 8'h05);
    for (int c = 0; c < 100; c++) begin
      @(negedge aclk);
      if (m_axis_tvalid && m_axis_tdata[7:0] == 8'd33) begin found = 1; break; end
    end
    n_cmp++; if (!found) begin
      n_fail++; $display("FAIL mid_reach_beat1: pkt1 beat1 not seen");
    end
    #2 aresetn = 1'b0;
    #1;
    $display("async reset asserted mid-packet");
    n_cmp++; if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== '0 ||
                 m_axis_tstrb !== '0 || m_axis_tuser !== '0) begin
      n_fail++; $display("FAIL mid_reset_outputs: tvalid=%b tdata=%h expected 0 0", m_axis_tvalid, m_axis_tdata);
    end
    n_cmp++; if (counter !== 8'd0 || busy !== 1'b0 || activity_send !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_status: counter=%0d busy=%b act=%b expected 0 0 0", counter, busy, activity_send);
    end
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    n_cmp++; if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_after_release: tvalid=%b busy=%b expected 0 0", m_axis_tvalid, busy);
    end
    do_start(16'd64, 8'd1, 8'h03, 8'h05);
    @(negedge aclk);
    n_cmp++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_beat(0, 0)) begin
      n_fail++; $display("FAIL mid_restart: tvalid=%b tdata=%h expected 1 %h", m_axis_tvalid, m_axis_tdata, exp_beat(0, 0));
    end
    repeat (3) @(negedge aclk);
  endtask

  task automatic test_back_to_back();
    logic [7:0] lane0 [6];
    lane0 = '{8'h00, 8'h20, 8'h01, 8'h21, 8'h02, 8'h22};
    m_axis_tready = 1'b1;
    pkt_len  = 16'd64;
    num_pkts = 8'd3;
    start_b  = 1'b1;
    @(negedge aclk);
    start_b  = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge aclk);
      $display("b2b beat=%0d tvalid=%b tdata[7:0]=%h tlast=%b", k, b_tvalid, b_tdata[7:0], b_tlast);
      n_cmp++; if (b_tvalid !== 1'b1 || b_tdata[7:0] !== lane0[k] || b_tlast !== (k % 2 == 1)) begin
        n_fail++; $display("FAIL b2b_beat%0d: tvalid=%b byte=%h tlast=%b expected 1 %h %b",
                           k, b_tvalid, b_tdata[7:0], b_tlast, lane0[k], (k % 2 == 1));
      end
    end
    @(negedge aclk);
    n_cmp++; if (b_tvalid !== 1'b0 || b_counter !== 8'd3 || b_busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_done: tvalid=%b counter=%0d busy=%b expected 0 3 1", b_tvalid, b_counter, b_busy);
    end
    @(negedge aclk);
    n_cmp++; if (b_busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle: busy=%b expected 0", b_busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_partial();
    test_backpressure();
    test_gap_reject();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
